// File: rtl/bip_dmem_io.sv
// bip_dmem_io: data-memory subsystem for the BIP CPU data port.
// It splits the address space into a RAM region and a memory-mapped I/O region.
// The I/O region holds output registers, synchronised input ports and a compare timer with an IRQ line.
module bip_dmem_io #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       RAM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(11'h400),
  parameter int unsigned       N_OUT     = 4,
  parameter int unsigned       N_IN      = 4
) (
  input  logic                    CLOCK_i,
  input  logic                    RESET_i,
  input  logic                    WR_i,
  input  logic [ADDR_W-1:0]       ADDR_dm_i,
  input  logic [DATA_W-1:0]       IN_DATA_i,
  output logic [DATA_W-1:0]       OUT_DATA_o,
  input  logic [N_IN*DATA_W-1:0]  PORT_IN_i,
  output logic [N_OUT*DATA_W-1:0] PORT_OUT_o,
  output logic                    IRQ_o
);

  localparam int unsigned       RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] OFF_IN    = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] OFF_CNT   = ADDR_W'(32);
  localparam logic [ADDR_W-1:0] OFF_CMP   = ADDR_W'(33);
  localparam logic [ADDR_W-1:0] OFF_STAT  = ADDR_W'(34);
  localparam logic [ADDR_W-1:0] OFF_CTRL  = ADDR_W'(35);

  logic [DATA_W-1:0]       mem [RAM_DEPTH];
  logic [N_OUT*DATA_W-1:0] out_q;
  logic [N_IN*DATA_W-1:0]  sync1;
  logic [N_IN*DATA_W-1:0]  sync2;
  logic [DATA_W-1:0]       cnt;
  logic [DATA_W-1:0]       cmp;
  logic                    en;
  logic                    irq_en;
  logic                    match;

  logic                    is_ram;
  logic                    is_io;
  logic                    wr_io;
  logic [ADDR_W-1:0]       off;
  logic [RAM_AW-1:0]       ram_idx;
  logic                    sel_cnt;
  logic                    sel_cmp;
  logic                    sel_stat;
  logic                    sel_ctrl;
  logic                    hit;

  // Address decode; addresses between the RAM top and IO_BASE are unmapped.
  assign is_ram   = ({1'b0, ADDR_dm_i} < RAM_LIMIT);
  assign is_io    = (ADDR_dm_i >= IO_BASE);
  assign off      = ADDR_dm_i - IO_BASE;
  assign ram_idx  = ADDR_dm_i[RAM_AW-1:0];
  assign wr_io    = WR_i & is_io;
  assign sel_cnt  = wr_io & (off == OFF_CNT);
  assign sel_cmp  = wr_io & (off == OFF_CMP);
  assign sel_stat = wr_io & (off == OFF_STAT);
  assign sel_ctrl = wr_io & (off == OFF_CTRL);

  // Compare on the pre-increment count, gated by the current (pre-write) EN.
  assign hit = en & (cnt == cmp);

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge CLOCK_i) begin
    if (WR_i && is_ram) begin
      mem[ram_idx] <= IN_DATA_i;
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_i or posedge RESET_i) begin
    if (RESET_i) begin
      out_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (wr_io && (off == ADDR_W'(k))) begin
          out_q[k*DATA_W +: DATA_W] <= IN_DATA_i;
        end
      end
    end
  end

  // Two-flop synchroniser for the asynchronous input ports.
  always_ff @(posedge CLOCK_i or posedge RESET_i) begin
    if (RESET_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= PORT_IN_i;
      sync2 <= sync1;
    end
  end

  // Compare timer: CPU write to CNT beats the increment, a new match beats a clear.
  always_ff @(posedge CLOCK_i or posedge RESET_i) begin
    if (RESET_i) begin
      cnt    <= '0;
      cmp    <= '1;
      en     <= 1'b0;
      irq_en <= 1'b0;
      match  <= 1'b0;
    end else begin
      if (sel_cnt) begin
        cnt <= IN_DATA_i;
      end else if (en) begin
        cnt <= cnt + DATA_W'(1);
      end
      if (sel_cmp) begin
        cmp <= IN_DATA_i;
      end
      if (sel_ctrl) begin
        en     <= IN_DATA_i[0];
        irq_en <= IN_DATA_i[1];
      end
      if (hit) begin
        match <= 1'b1;
      end else if (sel_stat && IN_DATA_i[0]) begin
        match <= 1'b0;
      end
    end
  end

  // Combinational read mux from the current address.
  always_comb begin
    OUT_DATA_o = '0;
    if (is_ram) begin
      OUT_DATA_o = mem[ram_idx];
    end else if (is_io) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (off == ADDR_W'(k)) begin
          OUT_DATA_o = out_q[k*DATA_W +: DATA_W];
        end
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (off == (OFF_IN + ADDR_W'(k))) begin
          OUT_DATA_o = sync2[k*DATA_W +: DATA_W];
        end
      end
      if (off == OFF_CNT) begin
        OUT_DATA_o = cnt;
      end
      if (off == OFF_CMP) begin
        OUT_DATA_o = cmp;
      end
      if (off == OFF_STAT) begin
        OUT_DATA_o = {{(DATA_W-1){1'b0}}, match};
      end
      if (off == OFF_CTRL) begin
        OUT_DATA_o = {{(DATA_W-2){1'b0}}, irq_en, en};
      end
    end
  end

  assign PORT_OUT_o = out_q;
  assign IRQ_o      = match & irq_en;

endmodule

// File: tb/tb_bip_dmem_io.sv
// Testbench for bip_dmem_io: it runs directed vectors against a behavioural memory-map model.
// It also makes literal checks at the timing-critical points.
`timescale 1ns/1ps
module tb_bip_dmem_io;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned RAM_DEPTH = 922;   // 0x39A leaves an unmapped gap below IO_BASE
  localparam int          IO_BASE   = 'h400;
  localparam int unsigned N_OUT     = 4;
  localparam int unsigned N_IN      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [10:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [63:0] port_in = 64'h4444_3333_1111_0000;
  logic [63:0] port_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bip_dmem_io #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH),
    .IO_BASE(11'h400), .N_OUT(N_OUT), .N_IN(N_IN)
  ) dut (
    .CLOCK_i(clk), .RESET_i(rst), .WR_i(wr), .ADDR_dm_i(addr),
    .IN_DATA_i(wdata), .OUT_DATA_o(rdata), .PORT_IN_i(port_in),
    .PORT_OUT_o(port_out), .IRQ_o(irq)
  );

  // Behavioural model of the memory map
  logic [15:0] m_mem [int];
  logic [15:0] m_out [4];
  logic [15:0] m_cnt, m_cmp;
  logic        m_en, m_irqen, m_match;
  logic [63:0] pin_q [$] = '{64'h0, 64'h0};   // port samples of the last two edges

  // Returns {valid, value}; RAM words never written are not predictable.
  function automatic logic [16:0] model_read(input int a);
    int off;
    logic [63:0] v;
    if (a < int'(RAM_DEPTH)) return m_mem.exists(a) ? {1'b1, m_mem[a]} : 17'h0;
    if (a < IO_BASE) return {1'b1, 16'h0};
    off = a - IO_BASE;
    if (off < int'(N_OUT)) return {1'b1, m_out[off]};
    if (off >= 16 && off < 16 + int'(N_IN)) begin
      v = pin_q[0];
      return {1'b1, v[(off-16)*16 +: 16]};
    end
    case (off)
      32:      return {1'b1, m_cnt};
      33:      return {1'b1, m_cmp};
      34:      return {1'b1, 15'h0, m_match};
      35:      return {1'b1, 14'h0, m_irqen, m_en};
      default: return {1'b1, 16'h0};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) m_out[k] = 16'h0;
      m_cnt = 16'h0; m_cmp = 16'hFFFF;
      m_en = 1'b0; m_irqen = 1'b0; m_match = 1'b0;
      pin_q = '{64'h0, 64'h0};
    end else begin
      int a, off;
      logic fire;
      logic [15:0] next_cnt;
      a = int'(addr);
      off = a - IO_BASE;
      fire = m_en && (m_cnt == m_cmp);
      next_cnt = m_en ? 16'((32'(m_cnt) + 1) % 65536) : m_cnt;
      if (wr) begin
        if (a < int'(RAM_DEPTH)) m_mem[a] = wdata;
        else if (a >= IO_BASE) begin
          if (off < int'(N_OUT)) m_out[off] = wdata;
          else if (off == 32) next_cnt = wdata;
          else if (off == 33) m_cmp = wdata;
          else if (off == 34 && wdata[0]) m_match = 1'b0;
          else if (off == 35) begin m_en = wdata[0]; m_irqen = wdata[1]; end
        end
      end
      if (fire) m_match = 1'b1;
      m_cnt = next_cnt;
      pin_q.push_back(port_in);
      void'(pin_q.pop_front());
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [16:0] e;
    e = model_read(int'(addr));
    if (e[16]) chk("cyc_rdata", 64'(rdata), 64'(e[15:0]));
    chk("cyc_port_out", port_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
    chk("cyc_irq", 64'(irq), 64'(m_match & m_irqen));
  end

  // All stimulus tasks start and end 2 ns after a rising edge.
  task automatic cyc_wr(input logic [10:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #2;
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rd_chk(input logic [10:0] a, input logic [15:0] exp, input string name);
    wr = 1'b0; addr = a;
    #0.2;
    chk(name, 64'(rdata), 64'(exp));
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state
    rd_chk(11'h421, 16'hFFFF, "rst_cmp");
    rd_chk(11'h420, 16'h0000, "rst_cnt");
    rd_chk(11'h423, 16'h0000, "rst_ctrl");
    rd_chk(11'h411, 16'h0000, "rst_sync");
    chk("rst_port_out", port_out, 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);

    // RAM and unmapped / undefined I/O addresses
    cyc_wr(11'h005, 16'hBEEF);
    cyc_wr(11'h399, 16'hAAAA);
    cyc_wr(11'h39A, 16'h0123);
    cyc_wr(11'h3FF, 16'h5555);
    cyc_wr(11'h405, 16'h7777);
    cyc_wr(11'h424, 16'h7777);
    rd_chk(11'h005, 16'hBEEF, "ram_lo");
    rd_chk(11'h399, 16'hAAAA, "ram_top");
    rd_chk(11'h39A, 16'h0000, "unmapped_39a");
    rd_chk(11'h3FF, 16'h0000, "unmapped_3ff");
    rd_chk(11'h405, 16'h0000, "io_hole_405");
    rd_chk(11'h424, 16'h0000, "io_hole_424");
    chk("hole_no_port_out", port_out, 64'h0);

    // Output register: visible on the pins after the write edge
    chk("out2_before", 64'(port_out[47:32]), 64'h0);
    cyc_wr(11'h402, 16'h00F0);
    chk("out2_after", 64'(port_out[47:32]), 64'h00F0);
    rd_chk(11'h402, 16'h00F0, "out2_read");

    // Input port: two-edge synchroniser latency
    port_in[31:16] = 16'h5A5A;
    rd_chk(11'h411, 16'h1111, "in1_edge0");
    idle(1);
    rd_chk(11'h411, 16'h1111, "in1_edge1");
    idle(1);
    rd_chk(11'h411, 16'h5A5A, "in1_edge2");
    rd_chk(11'h413, 16'h4444, "in3");

    // Timer match with CMP=5: MATCH at the edge where CNT goes 5 -> 6
    cyc_wr(11'h421, 16'h0005);
    cyc_wr(11'h420, 16'h0000);
    cyc_wr(11'h423, 16'h0003);
    idle(5);
    rd_chk(11'h422, 16'h0000, "stat_before_match");
    chk("irq_before_match", 64'(irq), 64'h0);
    rd_chk(11'h420, 16'h0005, "cnt_at_5");
    idle(1);
    chk("irq_at_match", 64'(irq), 64'h1);
    rd_chk(11'h422, 16'h0001, "stat_at_match");
    rd_chk(11'h420, 16'h0006, "cnt_at_6");
    cyc_wr(11'h422, 16'h0001);
    chk("irq_cleared", 64'(irq), 64'h0);
    rd_chk(11'h422, 16'h0000, "stat_cleared");

    // Wrap and CPU-write collision with the increment
    cyc_wr(11'h420, 16'hFFFF);
    rd_chk(11'h420, 16'hFFFF, "cnt_ffff");
    idle(1);
    rd_chk(11'h420, 16'h0000, "cnt_wrap");
    cyc_wr(11'h420, 16'h0010);
    rd_chk(11'h420, 16'h0010, "cnt_write_wins");
    idle(1);
    rd_chk(11'h420, 16'h0011, "cnt_resume");

    // Clear in the match cycle: set wins
    cyc_wr(11'h420, 16'h0005);
    cyc_wr(11'h422, 16'h0001);
    chk("irq_set_wins", 64'(irq), 64'h1);
    rd_chk(11'h422, 16'h0001, "stat_set_wins");
    cyc_wr(11'h422, 16'h0001);
    rd_chk(11'h422, 16'h0000, "stat_clear2");

    // Disabled timer: CTRL upper bits ignored, CNT held, no match
    cyc_wr(11'h423, 16'hFFFC);
    rd_chk(11'h423, 16'h0000, "ctrl_masked");
    cyc_wr(11'h421, 16'h0007);
    cyc_wr(11'h420, 16'h0007);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      rd_chk(11'h420, 16'h0007, "cnt_held");
      rd_chk(11'h422, 16'h0000, "no_match_disabled");
    end

    // Reset mid-run with CNT=0x1234 and MATCH=1
    cyc_wr(11'h423, 16'h0003);
    cyc_wr(11'h421, 16'h1233);
    cyc_wr(11'h420, 16'h1233);
    idle(1);
    rd_chk(11'h420, 16'h1234, "cnt_pre_reset");
    chk("irq_pre_reset", 64'(irq), 64'h1);
    @(negedge clk); #1;
    rst = 1'b1;
    #0.5;
    chk("async_irq", 64'(irq), 64'h0);
    chk("async_port_out", port_out, 64'h0);
    rd_chk(11'h420, 16'h0000, "async_cnt");
    rd_chk(11'h421, 16'hFFFF, "async_cmp");
    rd_chk(11'h422, 16'h0000, "async_stat");
    @(posedge clk); #2;
    rst = 1'b0;
    rd_chk(11'h005, 16'hBEEF, "ram_kept");
    rd_chk(11'h411, 16'h0000, "sync_reset0");
    idle(1);
    rd_chk(11'h411, 16'h0000, "sync_reset1");
    idle(1);
    rd_chk(11'h411, 16'h5A5A, "sync_reset2");
    rd_chk(11'h420, 16'h0000, "cnt_idle_after_reset");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
